// File: rtl/zeroheti_obi_demux.sv
// ============================================================================
// zeroheti_obi_demux
// ----------------------------------------------------------------------------
// Routes one upstream OBI subordinate port to NumMgrPorts downstream OBI
// targets. The target is chosen by address decode. Addresses that match no
// window go to an internal error target, which grants at once and answers one
// cycle later with err = 1 and rdata = ErrRdata.
//
// Responses come back in order because every in-flight transaction must go to
// the same target (cur_tgt). A request to a different target stalls until the
// outstanding counter drains to zero.
//
// Parameters
//   NumMgrPorts : number of downstream targets (1..8)
//   NumMaxTrans : maximum outstanding transactions (1..8)
//   RegionBase  : inclusive lower address of each target window
//   RegionLast  : inclusive upper address of each target window
//   ErrRdata    : rdata returned for a decode-error response
//
// Ports
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   sbr_req_i .. sbr_wdata_i : upstream request (req, addr, we, be, wdata)
//   sbr_gnt_o          : upstream grant (combinational)
//   sbr_rvalid_o, sbr_rdata_o, sbr_err_o : upstream response
//   mgr_req_o          : one-hot downstream request
//   mgr_addr_o .. mgr_wdata_o : downstream request payload, broadcast
//   mgr_gnt_i, mgr_rvalid_i, mgr_rdata_i, mgr_err_i : downstream handshakes
//   spurious_o         : one-cycle pulse after an unexpected downstream rvalid
// ============================================================================
module zeroheti_obi_demux #(
    parameter int unsigned NumMgrPorts = 3,
    parameter int unsigned NumMaxTrans = 2,
    // Packed arrays: the rightmost word in each concatenation is index 0.
    parameter logic [NumMgrPorts-1:0][31:0] RegionBase =
        {32'h0003_0000, 32'h0001_0000, 32'h0000_0000},
    parameter logic [NumMgrPorts-1:0][31:0] RegionLast =
        {32'h0003_00FF, 32'h0001_FFFF, 32'h0000_0FFF},
    parameter logic [31:0]                  ErrRdata   = 32'hBADC_AB1E
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,

    input  logic                          sbr_req_i,
    input  logic [31:0]                   sbr_addr_i,
    input  logic                          sbr_we_i,
    input  logic [3:0]                    sbr_be_i,
    input  logic [31:0]                   sbr_wdata_i,
    output logic                          sbr_gnt_o,
    output logic                          sbr_rvalid_o,
    output logic [31:0]                   sbr_rdata_o,
    output logic                          sbr_err_o,

    output logic [NumMgrPorts-1:0]        mgr_req_o,
    output logic [31:0]                   mgr_addr_o,
    output logic                          mgr_we_o,
    output logic [3:0]                    mgr_be_o,
    output logic [31:0]                   mgr_wdata_o,
    input  logic [NumMgrPorts-1:0]        mgr_gnt_i,
    input  logic [NumMgrPorts-1:0]        mgr_rvalid_i,
    input  logic [NumMgrPorts-1:0][31:0]  mgr_rdata_i,
    input  logic [NumMgrPorts-1:0]        mgr_err_i,

    output logic                          spurious_o
);

    // The target index needs one more code than there are ports. That extra
    // code (NumMgrPorts) names the internal error target.
    localparam int unsigned TgtW = $clog2(NumMgrPorts + 1);
    localparam int unsigned CntW = $clog2(NumMaxTrans + 1);

    localparam logic [TgtW-1:0] ErrTgt = TgtW'(NumMgrPorts);
    localparam logic [CntW-1:0] MaxCnt = CntW'(NumMaxTrans);

    logic [TgtW-1:0]        tgt;
    logic                   tgt_found;
    logic                   tgt_is_err;
    logic                   tgt_gnt;

    logic [CntW-1:0]        cnt;
    logic [CntW-1:0]        cnt_d;
    logic [TgtW-1:0]        cur_tgt;
    logic [TgtW-1:0]        cur_tgt_d;
    logic                   err_rsp_q;

    logic                   cnt_zero;
    logic                   cnt_full;
    logic                   allowed;

    logic                   rsp_valid;
    logic [31:0]            rsp_rdata;
    logic                   rsp_err;
    logic [NumMgrPorts-1:0] rsp_accept;
    logic                   spurious_d;

    // ------------------------------------------------------------------------
    // Address decode. The lowest matching index wins. The window test
    // (addr - base) <= (last - base) is an unsigned, inclusive range check in
    // one comparison. It assumes base <= last for every window.
    // ------------------------------------------------------------------------
    always_comb begin
        tgt       = ErrTgt;
        tgt_found = 1'b0;
        for (int unsigned i = 0; i < NumMgrPorts; i++) begin
            if (!tgt_found &&
                ((sbr_addr_i - RegionBase[i]) <= (RegionLast[i] - RegionBase[i]))) begin
                tgt       = TgtW'(i);
                tgt_found = 1'b1;
            end
        end
    end

    assign tgt_is_err = (tgt == ErrTgt);
    assign cnt_zero   = (cnt == '0);
    assign cnt_full   = (cnt == MaxCnt);

    // Including rst_ni here forces every request-side output low while reset
    // is asserted, even when the upstream keeps sbr_req_i high.
    assign allowed = rst_ni && sbr_req_i && !cnt_full &&
                     (cnt_zero || (tgt == cur_tgt));

    // ------------------------------------------------------------------------
    // Request steering and grant selection. mgr_req_o depends only on the
    // upstream request and the registered state, never on mgr_gnt_i, so the
    // downstream request stays stable while it waits for a grant.
    // ------------------------------------------------------------------------
    always_comb begin
        mgr_req_o = '0;
        tgt_gnt   = tgt_is_err;
        for (int unsigned i = 0; i < NumMgrPorts; i++) begin
            mgr_req_o[i] = allowed && (tgt == TgtW'(i));
            if (tgt == TgtW'(i)) begin
                tgt_gnt = mgr_gnt_i[i];
            end
        end
    end

    assign sbr_gnt_o = allowed && tgt_gnt;

    // The payload goes to every port. It is zeroed during reset so that all
    // outputs read 0 while reset is asserted.
    assign mgr_addr_o  = rst_ni ? sbr_addr_i  : '0;
    assign mgr_we_o    = rst_ni ? sbr_we_i    : 1'b0;
    assign mgr_be_o    = rst_ni ? sbr_be_i    : '0;
    assign mgr_wdata_o = rst_ni ? sbr_wdata_i : '0;

    // ------------------------------------------------------------------------
    // Response path. Only cur_tgt may respond, and only while something is
    // outstanding. A mapped target's rdata/err pass through whenever cnt > 0.
    // The error target produces its response from err_rsp_q.
    // ------------------------------------------------------------------------
    always_comb begin
        rsp_valid  = 1'b0;
        rsp_rdata  = '0;
        rsp_err    = 1'b0;
        rsp_accept = '0;
        if (!cnt_zero) begin
            if (cur_tgt == ErrTgt) begin
                rsp_valid = err_rsp_q;
                rsp_rdata = err_rsp_q ? ErrRdata : '0;
                rsp_err   = err_rsp_q;
            end
            for (int unsigned i = 0; i < NumMgrPorts; i++) begin
                if (cur_tgt == TgtW'(i)) begin
                    rsp_accept[i] = 1'b1;
                    rsp_valid     = mgr_rvalid_i[i];
                    rsp_rdata     = mgr_rdata_i[i];
                    rsp_err       = mgr_err_i[i];
                end
            end
        end
    end

    assign sbr_rvalid_o = rsp_valid;
    assign sbr_rdata_o  = rsp_rdata;
    assign sbr_err_o    = rsp_err;

    // An rvalid that is not accepted above is dropped. Such an rvalid comes
    // from a port other than cur_tgt, or arrives while nothing is outstanding.
    assign spurious_d = |(mgr_rvalid_i & ~rsp_accept);

    // ------------------------------------------------------------------------
    // Outstanding counter and current target, next-state logic. A grant and a
    // response in the same cycle cancel out. The allowed term keeps cnt below
    // NumMaxTrans before an increment. Responses only pass when cnt > 0.
    // ------------------------------------------------------------------------
    always_comb begin
        cnt_d     = cnt;
        cur_tgt_d = cur_tgt;
        if (sbr_gnt_o) begin
            cur_tgt_d = tgt;
        end
        if (sbr_gnt_o && !sbr_rvalid_o) begin
            cnt_d = cnt + CntW'(1);
        end else if (!sbr_gnt_o && sbr_rvalid_o) begin
            cnt_d = cnt - CntW'(1);
        end
    end

    // ------------------------------------------------------------------------
    // State registers. A reset drops everything that was in flight. Responses
    // that arrive after reset is released then count as spurious.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt        <= '0;
            cur_tgt    <= '0;
            err_rsp_q  <= 1'b0;
            spurious_o <= 1'b0;
        end else begin
            cnt        <= cnt_d;
            cur_tgt    <= cur_tgt_d;
            err_rsp_q  <= sbr_gnt_o && tgt_is_err;
            spurious_o <= spurious_d;
        end
    end

endmodule

// File: tb/tb_zeroheti_obi_demux.sv
// ============================================================================
// tb_zeroheti_obi_demux
// ----------------------------------------------------------------------------
// Directed bench for zeroheti_obi_demux with its default parameters.
// A reference model holds the in-flight transactions as a queue of target
// indices. On every falling edge it works out what every DUT output must be.
// Hand-computed literal checks pin the key scenarios.
// ============================================================================
module tb_zeroheti_obi_demux;

    localparam int NP = 3;
    localparam int MT = 2;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic                 sbr_req_i;
    logic [31:0]          sbr_addr_i;
    logic                 sbr_we_i;
    logic [3:0]           sbr_be_i;
    logic [31:0]          sbr_wdata_i;
    logic                 sbr_gnt_o;
    logic                 sbr_rvalid_o;
    logic [31:0]          sbr_rdata_o;
    logic                 sbr_err_o;
    logic [NP-1:0]        mgr_req_o;
    logic [31:0]          mgr_addr_o;
    logic                 mgr_we_o;
    logic [3:0]           mgr_be_o;
    logic [31:0]          mgr_wdata_o;
    logic [NP-1:0]        mgr_gnt_i;
    logic [NP-1:0]        mgr_rvalid_i;
    logic [NP-1:0][31:0]  mgr_rdata_i;
    logic [NP-1:0]        mgr_err_i;
    logic                 spurious_o;

    int checks = 0;
    int errors = 0;

    // Address map, held in variables and loaded at time 0.
    logic [31:0] tb_base [NP];
    logic [31:0] tb_last [NP];

    // Model state: the targets of in-flight transactions (oldest first), a
    // decode-error response due this cycle, and a spurious pulse due this
    // cycle.
    int   outq [$];
    logic err_now;
    logic spur_now;

    zeroheti_obi_demux dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .sbr_req_i    (sbr_req_i),
        .sbr_addr_i   (sbr_addr_i),
        .sbr_we_i     (sbr_we_i),
        .sbr_be_i     (sbr_be_i),
        .sbr_wdata_i  (sbr_wdata_i),
        .sbr_gnt_o    (sbr_gnt_o),
        .sbr_rvalid_o (sbr_rvalid_o),
        .sbr_rdata_o  (sbr_rdata_o),
        .sbr_err_o    (sbr_err_o),
        .mgr_req_o    (mgr_req_o),
        .mgr_addr_o   (mgr_addr_o),
        .mgr_we_o     (mgr_we_o),
        .mgr_be_o     (mgr_be_o),
        .mgr_wdata_o  (mgr_wdata_o),
        .mgr_gnt_i    (mgr_gnt_i),
        .mgr_rvalid_i (mgr_rvalid_i),
        .mgr_rdata_i  (mgr_rdata_i),
        .mgr_err_i    (mgr_err_i),
        .spurious_o   (spurious_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Returns the first window that contains the address, or NP if none does.
    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < NP; i++) begin
            if (a >= tb_base[i] && a <= tb_last[i]) return i;
        end
        return NP;
    endfunction

    // Drive one cycle of stimulus just after the rising edge. Only ports with
    // rvalid set carry rdata; the rest carry ~rdata, so a wrong response mux
    // shows up. Returns at the next falling edge, when outputs are settled.
    task automatic applyStimulus(input logic req, input logic [31:0] addr,
                                 input logic we, input logic [NP-1:0] gnt,
                                 input logic [NP-1:0] rvalid,
                                 input logic [31:0] rdata,
                                 input logic [NP-1:0] rerr);
        @(posedge clk_i);
        #1;
        sbr_req_i    = req;
        sbr_addr_i   = addr;
        sbr_we_i     = we;
        sbr_be_i     = we ? 4'hF : 4'h3;
        sbr_wdata_i  = we ? ~addr : 32'h0;
        mgr_gnt_i    = gnt;
        mgr_rvalid_i = rvalid;
        mgr_err_i    = rerr;
        for (int i = 0; i < NP; i++) begin
            mgr_rdata_i[i] = rvalid[i] ? rdata : ~rdata;
        end
        @(negedge clk_i);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, '0, '0, 32'h0, '0);
    endtask

    // On every falling edge: compare each DUT output with the model's
    // expectation, then step the model across the next rising edge.
    always @(negedge clk_i) begin : model_cmp
        int            t;
        int            n;
        int            cur;
        logic          allowed;
        logic          e_gnt;
        logic          e_rv;
        logic          e_err;
        logic          spur_next;
        logic [31:0]   e_req;
        logic [31:0]   e_rdata;
        if (!rst_ni) begin
            checkOutput("rst_mgr_req",  32'(mgr_req_o),    32'h0);
            checkOutput("rst_gnt",      32'(sbr_gnt_o),    32'h0);
            checkOutput("rst_rvalid",   32'(sbr_rvalid_o), 32'h0);
            checkOutput("rst_rdata",    sbr_rdata_o,       32'h0);
            checkOutput("rst_err",      32'(sbr_err_o),    32'h0);
            checkOutput("rst_spurious", 32'(spurious_o),   32'h0);
            checkOutput("rst_mgr_addr", mgr_addr_o,        32'h0);
            outq.delete();
            err_now  = 1'b0;
            spur_now = 1'b0;
        end else begin
            t       = decode(sbr_addr_i);
            n       = outq.size();
            cur     = (n > 0) ? outq[n-1] : -1;
            allowed = sbr_req_i && (n < MT) && (n == 0 || t == cur);
            e_req   = (allowed && t < NP) ? (32'd1 << t) : 32'd0;
            e_gnt   = 1'b0;
            if (allowed) begin
                if (t == NP) e_gnt = 1'b1;
                else         e_gnt = mgr_gnt_i[t];
            end
            e_rv    = 1'b0;
            e_err   = 1'b0;
            e_rdata = 32'h0;
            if (n > 0 && cur == NP) begin
                e_rv    = err_now;
                e_err   = err_now;
                e_rdata = err_now ? 32'hBADC_AB1E : 32'h0;
            end else if (n > 0) begin
                e_rv    = mgr_rvalid_i[cur];
                e_err   = mgr_err_i[cur];
                e_rdata = mgr_rdata_i[cur];
            end

            checkOutput("mgr_req",   32'(mgr_req_o),    e_req);
            checkOutput("sbr_gnt",   32'(sbr_gnt_o),    32'(e_gnt));
            checkOutput("sbr_rvalid",32'(sbr_rvalid_o), 32'(e_rv));
            checkOutput("sbr_rdata", sbr_rdata_o,       e_rdata);
            checkOutput("sbr_err",   32'(sbr_err_o),    32'(e_err));
            checkOutput("spurious",  32'(spurious_o),   32'(spur_now));
            checkOutput("mgr_addr",  mgr_addr_o,        sbr_addr_i);
            checkOutput("mgr_we",    32'(mgr_we_o),     32'(sbr_we_i));
            checkOutput("mgr_be",    32'(mgr_be_o),     32'(sbr_be_i));
            checkOutput("mgr_wdata", mgr_wdata_o,       sbr_wdata_i);
            checkOutput("cnt",       32'(dut.cnt),      32'(n));

            spur_next = 1'b0;
            for (int i = 0; i < NP; i++) begin
                if (mgr_rvalid_i[i] && !(n > 0 && cur == i)) spur_next = 1'b1;
            end
            if (e_rv)  void'(outq.pop_front());
            if (e_gnt) outq.push_back(t);
            err_now  = e_gnt && (t == NP);
            spur_now = spur_next;
        end
    end

    // Safety net: the run always reaches a summary line.
    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        tb_base[0] = 32'h0000_0000; tb_last[0] = 32'h0000_0FFF;
        tb_base[1] = 32'h0001_0000; tb_last[1] = 32'h0001_FFFF;
        tb_base[2] = 32'h0003_0000; tb_last[2] = 32'h0003_00FF;
        err_now      = 1'b0;
        spur_now     = 1'b0;
        rst_ni       = 1'b0;
        // A live request during reset must still leave every output at 0.
        sbr_req_i    = 1'b1;
        sbr_addr_i   = 32'h0001_0004;
        sbr_we_i     = 1'b0;
        sbr_be_i     = 4'h0;
        sbr_wdata_i  = 32'h0;
        mgr_gnt_i    = '1;
        mgr_rvalid_i = '0;
        mgr_rdata_i  = '0;
        mgr_err_i    = '0;

        repeat (3) @(negedge clk_i);
        $display("[TB] reset state");
        checkOutput("lit_rst_req", 32'(mgr_req_o), 32'h0);
        checkOutput("lit_rst_gnt", 32'(sbr_gnt_o), 32'h0);
        @(posedge clk_i);
        #1;
        rst_ni    = 1'b1;
        sbr_req_i = 1'b0;
        mgr_gnt_i = '0;

        // Single read to port 1.
        $display("[TB] single read");
        applyStimulus(1'b1, 32'h0001_0004, 1'b0, 3'b010, 3'b000, 32'h0, 3'b000);
        checkOutput("lit_single_req", 32'(mgr_req_o), 32'h2);
        checkOutput("lit_single_gnt", 32'(sbr_gnt_o), 32'h1);
        idleCycle();
        checkOutput("lit_single_cnt1", 32'(dut.cnt), 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b0, 3'b000, 3'b010, 32'h1234_5678, 3'b000);
        checkOutput("lit_single_rvalid", 32'(sbr_rvalid_o), 32'h1);
        checkOutput("lit_single_rdata",  sbr_rdata_o, 32'h1234_5678);
        idleCycle();
        checkOutput("lit_single_cnt0", 32'(dut.cnt), 32'h0);

        // Back-to-back writes to port 0 until the limit is reached.
        $display("[TB] back-to-back");
        applyStimulus(1'b1, 32'h0000_0010, 1'b1, 3'b001, 3'b000, 32'h0, 3'b000);
        checkOutput("lit_b2b_gnt1", 32'(sbr_gnt_o), 32'h1);
        applyStimulus(1'b1, 32'h0000_0010, 1'b1, 3'b001, 3'b000, 32'h0, 3'b000);
        checkOutput("lit_b2b_gnt2", 32'(sbr_gnt_o), 32'h1);
        applyStimulus(1'b1, 32'h0000_0010, 1'b1, 3'b001, 3'b000, 32'h0, 3'b000);
        checkOutput("lit_b2b_stall_gnt", 32'(sbr_gnt_o), 32'h0);
        checkOutput("lit_b2b_stall_req", 32'(mgr_req_o), 32'h0);
        checkOutput("lit_b2b_cnt2", 32'(dut.cnt), 32'h2);
        applyStimulus(1'b1, 32'h0000_0010, 1'b1, 3'b001, 3'b001, 32'h0000_00A1, 3'b000);
        checkOutput("lit_b2b_rvalid1", 32'(sbr_rvalid_o), 32'h1);
        applyStimulus(1'b1, 32'h0000_0010, 1'b1, 3'b001, 3'b000, 32'h0, 3'b000);
        checkOutput("lit_b2b_gnt3", 32'(sbr_gnt_o), 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b0, 3'b000, 3'b001, 32'h0000_00A2, 3'b000);
        checkOutput("lit_b2b_cnt_full", 32'(dut.cnt), 32'h2);
        applyStimulus(1'b0, 32'h0, 1'b0, 3'b000, 3'b001, 32'h0000_00A3, 3'b000);
        idleCycle();
        checkOutput("lit_b2b_cnt0", 32'(dut.cnt), 32'h0);

        // Switching targets must wait for port 0 to drain.
        $display("[TB] target switch");
        applyStimulus(1'b1, 32'h0000_0020, 1'b0, 3'b001, 3'b000, 32'h0, 3'b000);
        applyStimulus(1'b1, 32'h0003_0000, 1'b0, 3'b100, 3'b000, 32'h0, 3'b000);
        checkOutput("lit_sw_req_blocked", 32'(mgr_req_o), 32'h0);
        checkOutput("lit_sw_gnt_blocked", 32'(sbr_gnt_o), 32'h0);
        applyStimulus(1'b1, 32'h0003_0000, 1'b0, 3'b100, 3'b001, 32'h0000_0B0B, 3'b000);
        checkOutput("lit_sw_req_rvalid_cycle", 32'(mgr_req_o), 32'h0);
        applyStimulus(1'b1, 32'h0003_0000, 1'b0, 3'b100, 3'b000, 32'h0, 3'b000);
        checkOutput("lit_sw_req_port2", 32'(mgr_req_o), 32'h4);
        checkOutput("lit_sw_gnt_port2", 32'(sbr_gnt_o), 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b0, 3'b000, 3'b100, 32'h0000_0003, 3'b100);
        checkOutput("lit_sw_rdata", sbr_rdata_o, 32'h0000_0003);
        checkOutput("lit_sw_err",   32'(sbr_err_o), 32'h1);
        idleCycle();

        // Unmapped address goes to the internal error target.
        $display("[TB] decode error");
        applyStimulus(1'b1, 32'h0002_0000, 1'b0, 3'b111, 3'b000, 32'h0, 3'b000);
        checkOutput("lit_err_gnt", 32'(sbr_gnt_o), 32'h1);
        checkOutput("lit_err_req", 32'(mgr_req_o), 32'h0);
        idleCycle();
        checkOutput("lit_err_rvalid", 32'(sbr_rvalid_o), 32'h1);
        checkOutput("lit_err_flag",   32'(sbr_err_o), 32'h1);
        checkOutput("lit_err_rdata",  sbr_rdata_o, 32'hBADC_AB1E);
        idleCycle();
        checkOutput("lit_err_done", 32'(sbr_rvalid_o), 32'h0);

        // Spurious response while idle.
        $display("[TB] spurious while idle");
        applyStimulus(1'b0, 32'h0, 1'b0, 3'b000, 3'b100, 32'h0000_0055, 3'b000);
        checkOutput("lit_spur_rvalid", 32'(sbr_rvalid_o), 32'h0);
        idleCycle();
        checkOutput("lit_spur_pulse", 32'(spurious_o), 32'h1);
        checkOutput("lit_spur_cnt",   32'(dut.cnt), 32'h0);
        idleCycle();
        checkOutput("lit_spur_end", 32'(spurious_o), 32'h0);

        // Response from the wrong port while port 1 is outstanding.
        $display("[TB] spurious wrong port");
        applyStimulus(1'b1, 32'h0001_0100, 1'b0, 3'b010, 3'b000, 32'h0, 3'b000);
        applyStimulus(1'b0, 32'h0, 1'b0, 3'b000, 3'b001, 32'h0000_0077, 3'b000);
        checkOutput("lit_wp_rvalid", 32'(sbr_rvalid_o), 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 3'b000, 3'b010, 32'h0000_0088, 3'b000);
        checkOutput("lit_wp_spur",  32'(spurious_o), 32'h1);
        checkOutput("lit_wp_rdata", sbr_rdata_o, 32'h0000_0088);
        idleCycle();

        // Reset while two transactions are in flight.
        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 32'h0000_0010, 1'b0, 3'b001, 3'b000, 32'h0, 3'b000);
        applyStimulus(1'b1, 32'h0000_0010, 1'b0, 3'b001, 3'b000, 32'h0, 3'b000);
        applyStimulus(1'b1, 32'h0000_0010, 1'b0, 3'b001, 3'b000, 32'h0, 3'b000);
        checkOutput("lit_mid_cnt2", 32'(dut.cnt), 32'h2);
        @(posedge clk_i);
        #1;
        mgr_rvalid_i = 3'b001;
        rst_ni       = 1'b0;
        #1;
        checkOutput("lit_mid_req",    32'(mgr_req_o),    32'h0);
        checkOutput("lit_mid_gnt",    32'(sbr_gnt_o),    32'h0);
        checkOutput("lit_mid_rvalid", 32'(sbr_rvalid_o), 32'h0);
        checkOutput("lit_mid_cnt",    32'(dut.cnt),      32'h0);
        @(negedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni    = 1'b1;
        sbr_req_i = 1'b0;
        @(negedge clk_i);
        checkOutput("lit_post_rvalid", 32'(sbr_rvalid_o), 32'h0);
        applyStimulus(1'b1, 32'h0001_0008, 1'b0, 3'b010, 3'b000, 32'h0, 3'b000);
        checkOutput("lit_post_spur", 32'(spurious_o), 32'h1);
        checkOutput("lit_post_req",  32'(mgr_req_o),  32'h2);
        checkOutput("lit_post_gnt",  32'(sbr_gnt_o),  32'h1);
        applyStimulus(1'b0, 32'h0, 1'b0, 3'b000, 3'b010, 32'hCAFE_0001, 3'b000);
        checkOutput("lit_post_rdata", sbr_rdata_o, 32'hCAFE_0001);
        idleCycle();
        checkOutput("lit_post_cnt0", 32'(dut.cnt), 32'h0);
        idleCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
